// File: rtl/burst_reg_bank_pkg.sv
// Shared constants and types for the burst register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package burst_reg_bank_pkg;

   // Register offsets above the buffer window (address - DEPTH)
   localparam logic [1:0] OFS_LENGTH    = 2'd0;
   localparam logic [1:0] OFS_MAX_BURST = 2'd1;
   localparam logic [1:0] OFS_CTRL      = 2'd2;
   localparam logic [1:0] OFS_STATUS    = 2'd3;

   // CTRL bit positions
   localparam int CTRL_START  = 0;
   localparam int CTRL_RW     = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bit positions
   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2
   } state_t;

endpackage

// File: rtl/burst_reg_bank_arbiter.sv
// Fixed-priority arbiter for the single buffer port, db over rc, with ack generation.
// Latency: ack is registered, one cycle after the grant.
// Backpressure: a losing rc request simply stays ungranted; it is granted the next free cycle.
module bank_arbiter (
   input  logic clk,
   input  logic rst_n,
   input  logic rc_req,
   input  logic rc_buf,
   input  logic db_req,
   input  logic db_buf,
   output logic rc_gnt,
   output logic db_gnt,
   output logic rc_ack,
   output logic db_ack
);

   logic rc_ack_d, rc_ack_q;
   logic db_ack_d, db_ack_q;

   // Only a simultaneous buffer access by both sides clashes; db takes it.
   always_comb begin
      db_gnt   = db_req;
      rc_gnt   = rc_req & ~(rc_buf & db_req & db_buf);
      rc_ack_d = rc_gnt;
      db_ack_d = db_gnt;
   end

   // Ack registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc_ack_q <= 1'b0;
         db_ack_q <= 1'b0;
      end else begin
         rc_ack_q <= rc_ack_d;
         db_ack_q <= db_ack_d;
      end
   end

   assign rc_ack = rc_ack_q;
   assign db_ack = db_ack_q;

endmodule

// File: rtl/burst_reg_bank.sv
// Register bank and data buffer shared by the APB controller (rc) and the burst engine (db).
// Latency: every access acks one cycle after it is granted; read data is registered.
// Backpressure: rc buffer accesses stall one cycle when db uses the buffer in the same cycle.
module burst_reg_bank
   import burst_reg_bank_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rc_req,
   input  logic              rc_wr,
   input  logic [ADDR_W-1:0] rc_addr,
   input  logic [DATA_W-1:0] rc_wdata,
   output logic              rc_ack,
   output logic [DATA_W-1:0] rc_rdata,
   output logic              rc_err,
   input  logic              db_req,
   input  logic              db_wr,
   input  logic [ADDR_W-1:0] db_addr,
   input  logic [DATA_W-1:0] db_wdata,
   output logic              db_ack,
   output logic [DATA_W-1:0] db_rdata,
   input  logic              db_done,
   output logic              db_start,
   output logic              db_rw,
   output logic [DATA_W-1:0] db_length,
   output logic [DATA_W-1:0] db_max_burst,
   output logic              irq,
   output logic              idle
);

   localparam int                IDX_W   = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   state_t            state_d, state_q;
   logic [DATA_W-1:0] length_d, length_q;
   logic [DATA_W-1:0] max_burst_d, max_burst_q;
   logic              rw_d, rw_q, irq_en_d, irq_en_q;
   logic              done_d, done_q, err_d, err_q;
   logic [DATA_W-1:0] rc_rdata_d, rc_rdata_q, db_rdata_d, db_rdata_q;
   logic              rc_err_d, rc_err_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic              rc_in_buf, rc_in_reg, db_in_buf, busy, start_ok;
   logic              rc_gnt, db_gnt;
   logic [1:0]        rc_ofs;
   logic [IDX_W-1:0]  rc_idx, db_idx;

   assign rc_in_buf = rc_addr < DEPTH_A;
   assign rc_in_reg = ~rc_in_buf && ((rc_addr - DEPTH_A) < ADDR_W'(4));
   assign db_in_buf = db_addr < DEPTH_A;
   assign rc_ofs    = rc_addr[1:0];
   assign rc_idx    = rc_addr[IDX_W-1:0];
   assign db_idx    = db_addr[IDX_W-1:0];
   assign busy      = state_q != S_IDLE;
   assign start_ok  = ~busy && (length_q != '0) && (max_burst_q != '0);

   bank_arbiter u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .rc_req (rc_req),
      .rc_buf (rc_in_buf),
      .db_req (db_req),
      .db_buf (db_in_buf),
      .rc_gnt (rc_gnt),
      .db_gnt (db_gnt),
      .rc_ack (rc_ack),
      .db_ack (db_ack)
   );

   // Access decode, register updates and start/busy FSM next state
   always_comb begin
      state_d     = state_q;
      length_d    = length_q;
      max_burst_d = max_burst_q;
      rw_d        = rw_q;
      irq_en_d    = irq_en_q;
      done_d      = done_q;
      err_d       = err_q;
      rc_rdata_d  = rc_rdata_q;
      db_rdata_d  = db_rdata_q;
      rc_err_d    = rc_err_q;
      mem_we      = 1'b0;
      mem_waddr   = '0;
      mem_wdata   = '0;

      if (state_q == S_START) state_d = S_BUSY;

      if (db_gnt) begin
         db_rdata_d = '0;
         if (db_in_buf) begin
            if (db_wr) begin
               mem_we    = 1'b1;
               mem_waddr = db_idx;
               mem_wdata = db_wdata;
            end else begin
               db_rdata_d = mem_q[db_idx];
            end
         end
      end

      if (rc_gnt) begin
         rc_rdata_d = '0;
         rc_err_d   = 1'b0;
         if (rc_in_buf) begin
            if (!rc_wr) rc_rdata_d = mem_q[rc_idx];
            else if (busy) rc_err_d = 1'b1;
            else begin
               mem_we    = 1'b1;
               mem_waddr = rc_idx;
               mem_wdata = rc_wdata;
            end
         end else if (rc_in_reg && !rc_wr) begin
            case (rc_ofs)
               OFS_LENGTH:    rc_rdata_d = length_q;
               OFS_MAX_BURST: rc_rdata_d = max_burst_q;
               OFS_CTRL: begin
                  rc_rdata_d[CTRL_RW]     = rw_q;
                  rc_rdata_d[CTRL_IRQ_EN] = irq_en_q;
               end
               OFS_STATUS: begin
                  rc_rdata_d[ST_BUSY] = busy;
                  rc_rdata_d[ST_DONE] = done_q;
                  rc_rdata_d[ST_ERR]  = err_q;
               end
            endcase
         end else if (rc_in_reg) begin
            if (rc_ofs == OFS_STATUS) begin
               if (rc_wdata[ST_DONE]) done_d = 1'b0;
               if (rc_wdata[ST_ERR])  err_d  = 1'b0;
            end else if (busy) begin
               // Config is frozen during a burst; a start attempt also flags STATUS.err
               rc_err_d = 1'b1;
               if (rc_ofs == OFS_CTRL && rc_wdata[CTRL_START]) err_d = 1'b1;
            end else if (rc_ofs == OFS_LENGTH) begin
               length_d = rc_wdata;
            end else if (rc_ofs == OFS_MAX_BURST) begin
               max_burst_d = rc_wdata;
            end else begin
               rw_d     = rc_wdata[CTRL_RW];
               irq_en_d = rc_wdata[CTRL_IRQ_EN];
               if (rc_wdata[CTRL_START]) begin
                  if (start_ok) begin
                     state_d = S_START;
                     done_d  = 1'b0;
                  end else begin
                     rc_err_d = 1'b1;
                     err_d    = 1'b1;
                  end
               end
            end
         end else begin
            rc_err_d = 1'b1;
         end
      end

      // Completion last so it beats a same-cycle W1C of done
      if (db_done && busy) begin
         state_d = S_IDLE;
         done_d  = 1'b1;
      end
   end

   // Control/status registers, FSM state and registered read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         length_q    <= '0;
         max_burst_q <= '0;
         rw_q        <= 1'b0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rc_rdata_q  <= '0;
         db_rdata_q  <= '0;
         rc_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         length_q    <= length_d;
         max_burst_q <= max_burst_d;
         rw_q        <= rw_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rc_rdata_q  <= rc_rdata_d;
         db_rdata_q  <= db_rdata_d;
         rc_err_q    <= rc_err_d;
      end
   end

   // Buffer storage is intentionally left unreset
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign rc_rdata     = rc_rdata_q;
   assign rc_err       = rc_err_q;
   assign db_rdata     = db_rdata_q;
   assign db_start     = state_q == S_START;
   assign db_rw        = rw_q;
   assign db_length    = length_q;
   assign db_max_burst = max_burst_q;
   assign irq          = done_q & irq_en_q;
   assign idle         = ~busy & ~db_start & ~rc_req & ~db_req;

endmodule
